// File: rtl/chain_mon_pkg.sv
// ---------------------------------------------------------------------------
// chain_mon_pkg
// Shared types and default parameter values for the delay-chain receive
// monitor (chain_rx_monitor) and its capture shift register (chain_sync).
//
// Contents
//   state_t             monitor FSM state encoding
//   DEF_SYNC_STAGES     default capture depth on chain_in
//   DEF_LAT_W           default latency counter / output width
//   DEF_MAX_LAT         default WAIT cycles with no edge before TIMEOUT
//   DEF_ERR_W           default missed-toggle counter width
//   DEF_ERR_LIMIT       default missed toggles in TRACK that force FAIL
// ---------------------------------------------------------------------------
package chain_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    TRACK   = 3'd2,
    TIMEOUT = 3'd3,
    FAIL    = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LAT_W       = 4;
  localparam int DEF_MAX_LAT     = 15;
  localparam int DEF_ERR_W       = 8;
  localparam int DEF_ERR_LIMIT   = 4;

endpackage

// File: rtl/chain_sync.sv
// ---------------------------------------------------------------------------
// chain_sync
// STAGES-deep capture shift register that retimes the far end of the delay
// chain into the monitor clock domain. Every stage clears on reset.
//
// Ports
//   clk  in   1  rising-edge clock
//   rst  in   1  synchronous, active-high reset
//   d    in   1  raw chain output
//   q    out  1  last capture stage
// ---------------------------------------------------------------------------
module chain_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sh;

  // A per-bit loop keeps STAGES == 1 legal (no empty slice).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else begin
      r_sh[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_sh[i] <= r_sh[i-1];
      end
    end
  end

  assign q = r_sh[STAGES-1];

endmodule

// File: rtl/chain_rx_monitor.sv
// ---------------------------------------------------------------------------
// chain_rx_monitor
// Receive end of a toggle-launch delay-chain timing path. The launch side
// toggles a flop every cycle while armed; this block retimes the chain
// output, measures how many cycles pass between sampling arm and seeing the
// first edge, then checks that the captured signal keeps toggling every
// cycle. It flags a timeout (no edge in time) or too many missed toggles.
//
// Ports
//   tau2015_clk  in   1      single clock, rising edge
//   tau2015_rst  in   1      synchronous, active-high reset
//   arm          in   1      1 = measure / keep tracking, 0 = back to IDLE
//   chain_in     in   1      far end of the delay chain
//   rx_q         out  1      retimed chain_in (last capture stage)
//   locked       out  1      high while in TRACK
//   fail         out  1      high while in TIMEOUT or FAIL
//   latency      out  LAT_W  cycles from arm sample to first edge at rx_q
//   err_cnt      out  ERR_W  missed toggles since entering TRACK
//   o_dbg_state  out  3      current FSM state, for observation only
//
// Every output is a register or the captured chain value; chain_in reaches
// no output except through the capture flops.
// ---------------------------------------------------------------------------
module chain_rx_monitor
  import chain_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LAT_W       = DEF_LAT_W,
  parameter int MAX_LAT     = DEF_MAX_LAT,
  parameter int ERR_W       = DEF_ERR_W,
  parameter int ERR_LIMIT   = DEF_ERR_LIMIT
) (
  input  logic             tau2015_clk,
  input  logic             tau2015_rst,
  input  logic             arm,
  input  logic             chain_in,
  output logic             rx_q,
  output logic             locked,
  output logic             fail,
  output logic [LAT_W-1:0] latency,
  output logic [ERR_W-1:0] err_cnt,
  output state_t           o_dbg_state
);

  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] LAT_SAT   = {LAT_W{1'b1}};
  // Miss that takes err_cnt to ERR_LIMIT is the one seen with this value.
  localparam logic [ERR_W-1:0] ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
  localparam logic [ERR_W-1:0] ERR_SAT   = {ERR_W{1'b1}};

  logic             w_rx_q;
  logic             w_edge;
  logic             r_prev_q;
  state_t           r_state;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] r_latency;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_locked;
  logic             r_fail;

  chain_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (tau2015_clk),
    .rst (tau2015_rst),
    .d   (chain_in),
    .q   (w_rx_q)
  );

  // Any change of the captured value between consecutive cycles.
  assign w_edge = w_rx_q ^ r_prev_q;

  // Single registered FSM. locked/fail are updated together with the state
  // so they are always exact decodes of r_state, just held in flops.
  always_ff @(posedge tau2015_clk) begin
    if (tau2015_rst) begin
      r_prev_q  <= 1'b0;
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_latency <= '0;
      r_err_cnt <= '0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_prev_q <= w_rx_q;

      if (!arm) begin
        // Disarm beats any same-cycle miss, edge or timeout: counters and
        // latency are left exactly as they were.
        r_state  <= IDLE;
        r_locked <= 1'b0;
        r_fail   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state   <= WAIT;
            r_lat_cnt <= '0;
            r_err_cnt <= '0;
          end

          WAIT: begin
            if (w_edge) begin
              // An edge on the timeout cycle still counts as a lock.
              // lat_cnt+1 is clipped so a full-range counter cannot wrap.
              if (r_lat_cnt == LAT_SAT) begin
                r_latency <= LAT_SAT;
              end else begin
                r_latency <= r_lat_cnt + 1'b1;
              end
              r_state  <= TRACK;
              r_locked <= 1'b1;
            end else if (r_lat_cnt == LAT_LIMIT) begin
              // Checked before incrementing, so lat_cnt never wraps.
              r_latency <= LAT_LIMIT;
              r_state   <= TIMEOUT;
              r_fail    <= 1'b1;
            end else begin
              r_lat_cnt <= r_lat_cnt + 1'b1;
            end
          end

          TRACK: begin
            if (!w_edge) begin
              if (r_err_cnt != ERR_SAT) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
              if (r_err_cnt == ERR_LAST) begin
                r_state  <= FAIL;
                r_locked <= 1'b0;
                r_fail   <= 1'b1;
              end
            end
          end

          TIMEOUT, FAIL: begin
            // Sticky until disarm or reset.
            r_state <= r_state;
          end

          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_q        = w_rx_q;
  assign locked      = r_locked;
  assign fail        = r_fail;
  assign latency     = r_latency;
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chain_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_chain_rx_monitor
// Directed bench for chain_rx_monitor. Instance a uses default parameters;
// instance b uses MAX_LAT=14 and shares all inputs, so the lock/timeout
// boundary can be seen on both sides at once. chain_in is driven from a
// toggle model: each drive() call either toggles it or repeats (stalls).
// ---------------------------------------------------------------------------
module tb_chain_rx_monitor;
  import chain_mon_pkg::*;

  logic       clk;
  logic       rst;
  logic       arm;
  logic       chain_in;
  logic       tgl;

  logic       a_rx_q, a_locked, a_fail;
  logic [3:0] a_latency;
  logic [7:0] a_err_cnt;
  state_t     a_state;

  logic       b_rx_q, b_locked, b_fail;
  logic [3:0] b_latency;
  logic [7:0] b_err_cnt;
  state_t     b_state;

  int n_vec;
  int n_err;

  chain_rx_monitor u_dut_a (
    .tau2015_clk (clk),
    .tau2015_rst (rst),
    .arm         (arm),
    .chain_in    (chain_in),
    .rx_q        (a_rx_q),
    .locked      (a_locked),
    .fail        (a_fail),
    .latency     (a_latency),
    .err_cnt     (a_err_cnt),
    .o_dbg_state (a_state)
  );

  chain_rx_monitor #(
    .MAX_LAT (14)
  ) u_dut_b (
    .tau2015_clk (clk),
    .tau2015_rst (rst),
    .arm         (arm),
    .chain_in    (chain_in),
    .rx_q        (b_rx_q),
    .locked      (b_locked),
    .fail        (b_fail),
    .latency     (b_latency),
    .err_cnt     (b_err_cnt),
    .o_dbg_state (b_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the launch model: toggle chain_in, or repeat it if stall.
  task automatic drive(input bit stall);
    if (!stall) tgl = ~tgl;
    chain_in = tgl;
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    arm      = 1'b0;
    tgl      = 1'b0;
    chain_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // arm at cycle 0, chain toggles from cycle 3: edge seen at the 6th edge.
  task automatic lock_up();
    arm      = 1'b1;
    chain_in = 1'b0;
    tick();
    tick();
    tick();
    drive(0);
    drive(0);
    drive(0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL rst_locked got=%0b exp=0", a_locked); end
    n_vec++; if (a_fail !== 1'b0) begin n_err++; $display("FAIL rst_fail got=%0b exp=0", a_fail); end
    n_vec++; if (a_latency !== 4'd0) begin n_err++; $display("FAIL rst_latency got=%0d exp=0", a_latency); end
    n_vec++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL rst_err_cnt got=%0d exp=0", a_err_cnt); end
    n_vec++; if (a_rx_q !== 1'b0) begin n_err++; $display("FAIL rst_rx_q got=%0b exp=0", a_rx_q); end
    n_vec++; if (a_state !== IDLE) begin n_err++; $display("FAIL rst_state got=%0d exp=%0d", a_state, IDLE); end
  endtask

  task automatic test_latency();
    do_reset();
    arm      = 1'b1;
    chain_in = 1'b0;
    tick();
    n_vec++; if (a_state !== WAIT) begin n_err++; $display("FAIL lat_wait_state got=%0d exp=%0d", a_state, WAIT); end
    tick();
    tick();
    drive(0);
    drive(0);
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL lat_early_lock got=%0b exp=0", a_locked); end
    drive(0);
    n_vec++; if (a_locked !== 1'b1) begin n_err++; $display("FAIL lat_locked got=%0b exp=1", a_locked); end
    n_vec++; if (a_latency !== 4'd5) begin n_err++; $display("FAIL lat_value got=%0d exp=5", a_latency); end
    repeat (100) drive(0);
    n_vec++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL lat_track_err got=%0d exp=0", a_err_cnt); end
    n_vec++; if (a_locked !== 1'b1) begin n_err++; $display("FAIL lat_track_locked got=%0b exp=1", a_locked); end
    n_vec++; if (a_fail !== 1'b0) begin n_err++; $display("FAIL lat_track_fail got=%0b exp=0", a_fail); end
  endtask

  task automatic test_timeout();
    do_reset();
    arm      = 1'b1;
    chain_in = 1'b0;
    // WAIT entered at edge 1, lat_cnt hits 15 before edge 17.
    repeat (16) tick();
    n_vec++; if (a_fail !== 1'b0) begin n_err++; $display("FAIL to_early_fail got=%0b exp=0", a_fail); end
    tick();
    n_vec++; if (a_fail !== 1'b1) begin n_err++; $display("FAIL to_fail got=%0b exp=1", a_fail); end
    n_vec++; if (a_latency !== 4'd15) begin n_err++; $display("FAIL to_latency got=%0d exp=15", a_latency); end
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL to_locked got=%0b exp=0", a_locked); end
    // Toggling after a timeout must not recover while still armed.
    repeat (10) drive(0);
    n_vec++; if (a_state !== TIMEOUT) begin n_err++; $display("FAIL to_sticky got=%0d exp=%0d", a_state, TIMEOUT); end
    arm = 1'b0;
    tick();
    n_vec++; if (a_fail !== 1'b0) begin n_err++; $display("FAIL to_disarm_fail got=%0b exp=0", a_fail); end
    n_vec++; if (a_state !== IDLE) begin n_err++; $display("FAIL to_disarm_state got=%0d exp=%0d", a_state, IDLE); end
    n_vec++; if (a_latency !== 4'd15) begin n_err++; $display("FAIL to_latency_hold got=%0d exp=15", a_latency); end
  endtask

  task automatic test_missed();
    do_reset();
    lock_up();
    repeat (5) drive(0);
    // A stall in cycle k shows up as a missed edge at edge k+3.
    drive(1);
    drive(0);
    n_vec++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL miss_early got=%0d exp=0", a_err_cnt); end
    drive(0);
    n_vec++; if (a_err_cnt !== 8'd1) begin n_err++; $display("FAIL miss_one got=%0d exp=1", a_err_cnt); end
    n_vec++; if (a_locked !== 1'b1) begin n_err++; $display("FAIL miss_one_locked got=%0b exp=1", a_locked); end
    for (int s = 0; s < 2; s++) begin
      repeat (5) drive(0);
      drive(1);
      repeat (2) drive(0);
    end
    n_vec++; if (a_err_cnt !== 8'd3) begin n_err++; $display("FAIL miss_three got=%0d exp=3", a_err_cnt); end
    n_vec++; if (a_locked !== 1'b1) begin n_err++; $display("FAIL miss_three_locked got=%0b exp=1", a_locked); end
    repeat (5) drive(0);
    drive(1);
    repeat (2) drive(0);
    n_vec++; if (a_err_cnt !== 8'd4) begin n_err++; $display("FAIL miss_four got=%0d exp=4", a_err_cnt); end
    n_vec++; if (a_fail !== 1'b1) begin n_err++; $display("FAIL miss_fail got=%0b exp=1", a_fail); end
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL miss_fail_locked got=%0b exp=0", a_locked); end
    repeat (4) drive(1);
    n_vec++; if (a_err_cnt !== 8'd4) begin n_err++; $display("FAIL miss_sticky_cnt got=%0d exp=4", a_err_cnt); end
  endtask

  task automatic test_arm_drop_miss();
    do_reset();
    lock_up();
    repeat (4) drive(0);
    drive(1);
    drive(0);
    // The miss is sampled on the next edge, together with arm=0.
    arm = 1'b0;
    drive(0);
    n_vec++; if (a_state !== IDLE) begin n_err++; $display("FAIL drop_state got=%0d exp=%0d", a_state, IDLE); end
    n_vec++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL drop_err_cnt got=%0d exp=0", a_err_cnt); end
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL drop_locked got=%0b exp=0", a_locked); end
    n_vec++; if (a_latency !== 4'd5) begin n_err++; $display("FAIL drop_latency got=%0d exp=5", a_latency); end
  endtask

  task automatic test_boundary();
    // First edge seen with lat_cnt == 14: b (MAX_LAT=14) must lock, not time out.
    do_reset();
    arm      = 1'b1;
    chain_in = 1'b0;
    repeat (13) tick();
    drive(0);
    drive(0);
    n_vec++; if (b_fail !== 1'b0) begin n_err++; $display("FAIL bnd14_pre_fail got=%0b exp=0", b_fail); end
    drive(0);
    n_vec++; if (b_locked !== 1'b1) begin n_err++; $display("FAIL bnd14_b_locked got=%0b exp=1", b_locked); end
    n_vec++; if (b_latency !== 4'd15) begin n_err++; $display("FAIL bnd14_b_latency got=%0d exp=15", b_latency); end
    n_vec++; if (b_fail !== 1'b0) begin n_err++; $display("FAIL bnd14_b_fail got=%0b exp=0", b_fail); end
    n_vec++; if (a_latency !== 4'd15) begin n_err++; $display("FAIL bnd14_a_latency got=%0d exp=15", a_latency); end

    // First edge seen with lat_cnt == 15: a locks (latency clipped to 15),
    // b already timed out one edge earlier.
    do_reset();
    arm      = 1'b1;
    chain_in = 1'b0;
    repeat (14) tick();
    drive(0);
    drive(0);
    drive(0);
    n_vec++; if (a_locked !== 1'b1) begin n_err++; $display("FAIL bnd15_a_locked got=%0b exp=1", a_locked); end
    n_vec++; if (a_latency !== 4'd15) begin n_err++; $display("FAIL bnd15_a_latency got=%0d exp=15", a_latency); end
    n_vec++; if (b_fail !== 1'b1) begin n_err++; $display("FAIL bnd15_b_fail got=%0b exp=1", b_fail); end
    n_vec++; if (b_latency !== 4'd14) begin n_err++; $display("FAIL bnd15_b_latency got=%0d exp=14", b_latency); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    lock_up();
    repeat (6) drive(0);
    drive(1);
    repeat (3) drive(0);
    rst = 1'b1;
    drive(0);
    drive(0);
    n_vec++; if (a_locked !== 1'b0) begin n_err++; $display("FAIL mid_rst_locked got=%0b exp=0", a_locked); end
    n_vec++; if (a_fail !== 1'b0) begin n_err++; $display("FAIL mid_rst_fail got=%0b exp=0", a_fail); end
    n_vec++; if (a_latency !== 4'd0) begin n_err++; $display("FAIL mid_rst_latency got=%0d exp=0", a_latency); end
    n_vec++; if (a_err_cnt !== 8'd0) begin n_err++; $display("FAIL mid_rst_err_cnt got=%0d exp=0", a_err_cnt); end
    n_vec++; if (a_rx_q !== 1'b0) begin n_err++; $display("FAIL mid_rst_rx_q got=%0b exp=0", a_rx_q); end
    rst = 1'b0;
    tick();
    n_vec++; if (a_state !== WAIT) begin n_err++; $display("FAIL mid_rst_rearm got=%0d exp=%0d", a_state, WAIT); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    arm      = 1'b0;
    tgl      = 1'b0;
    chain_in = 1'b0;
    test_reset();
    test_latency();
    test_timeout();
    test_missed();
    test_arm_drop_miss();
    test_boundary();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
